time_set_ctrl: RTL and testbench
================================

# time_set_ctrl

Time-setting controller for the clock datapath: sequences user editing of hours, minutes and seconds from three debounced push-buttons, freezes the time counter while editing, and commits the edited value back to it with a one-cycle load. It also feeds the six-digit multiplexed display with either the live time or the edit value, plus a per-digit blank mask that blinks the field under edit. It sits between the button conditioning logic, the time counter (`tiempo`) and the display scanner.

## Interface
- `BLINK_HALF`, 25_000_000, cycles per blink half-period (on or off); ≥ 2.
- `TIMEOUT`, 500_000_000, cycles without a button press in an edit state before the edit is abandoned; > 2·`BLINK_HALF`.

- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `btn_mode`, `btn_up`, `btn_down`  in  1 each  debounced button levels, active-high.
- `cur_sec`  in  6  live seconds from the time counter (0..59).
- `cur_min`  in  6  live minutes (0..59).
- `cur_hour`  in  5  live hours (0..23).
- `count_en`  out  1  enable for the time counter; 0 freezes it.
- `load`  out  1  one-cycle pulse: time counter takes `load_*`.
- `load_sec` / `load_min` / `load_hour`  out  6/6/5  value to load.
- `disp_sec` / `disp_min` / `disp_hour`  out  6/6/5  value for the display.
- `blank`  out  6  1 = blank that digit; bit0 sec units, bit1 sec tens, bit2 min units, bit3 min tens, bit4 hour units, bit5 hour tens.
- `mode`  out  2  current state encoding (for LEDs).

## Operation
- Press = rising edge of a button level (registered previous value); a held button counts once.
- States: RUN(0), SET_H(1), SET_M(2), SET_S(3); COMMIT is a one-cycle transient, reported as `mode`=0.
- RUN: mode press → copy `cur_*` into edit registers, go SET_H, `count_en`←0. Up/down ignored.
- SET_H: up → edit_hour+1, 23 wraps to 0; down → −1, 0 wraps to 23. Mode press → SET_M.
- SET_M / SET_S: same with modulo 60 (59↔0). Mode in SET_M → SET_S; mode in SET_S → COMMIT.
- COMMIT: `load`=1, `load_*`=edit registers, `count_en`=1; next cycle RUN. Counter gives load priority over increment.
- Simultaneous up and down: both ignored. Mode together with up/down: mode wins, up/down ignored.
- Timeout: `TIMEOUT` cycles with no press in an edit state → RUN, no load, `count_en`←1, edit discarded.
- `disp_*`: `cur_*` in RUN/COMMIT, edit registers in SET_*.
- `blank`: 0 in RUN. In SET_* the two bits of the edited field are 1 during the off half-period, others 0. Blink phase restarts at "on" on entering a SET state and on every up/down press.
- Reset (including mid-edit): RUN, `count_en`=1, `load`=0, `load_*`=0, `disp_*`=0, `blank`=0, `mode`=0, edit registers 0, blink/timeout counters 0, previous-button registers 0. No load on reset.

## Timing
- All outputs registered.
- Press sampled in cycle N → new state, `mode`, `count_en`, `disp_*`, `blank` visible at N+1.
- Mode press in SET_S at N → `load`=1 at N+1 only; RUN at N+2.
- `disp_*` follows `cur_*` with one cycle of latency in RUN.
- Blink toggles every `BLINK_HALF` cycles; timeout counter resets on any press and on state entry.

## Structure
- Shared package `time_pkg`: `SEC_W`=6, `MIN_W`=6, `HOUR_W`=5, `MAX_SEC`=59, `MAX_MIN`=59, `MAX_HOUR`=23, state encoding constants, blank-bit index constants.
- Sub-module `blink_gen`: blink phase plus timeout counter with restart input, outputs `phase` and `expired`.
- Top holds the edge detectors, FSM, edit registers and modulo arithmetic.

## Test plan
Use `BLINK_HALF`=4, `TIMEOUT`=64.
- Reset mid-edit in SET_M → next cycle `mode`=0, `count_en`=1, `load` never pulses.
- cur=12:34:56, mode press → `count_en`=0, `disp`=12:34:56, `mode`=1, `blank` toggles 6'b110000/0 every 4 cycles.
- SET_H at 23, up → 0; down → 23. SET_M at 0, down → 59; SET_S at 59, up → 0.
- Edit to 07:08:09, mode through SET_S → exactly one `load` cycle with `load_*`=7/8/9 and `count_en`=1, then `mode`=0.
- Up+down same cycle → no change. Mode+up in SET_H → SET_M, hour unchanged.
- Hold up 20 cycles → single increment. Idle 64 cycles in SET_S → RUN, no load.

Source files
------------

// File: rtl/time_set_ctrl_pkg.sv
// time_pkg: shared widths, limits, state encoding and display blank-bit
// indices for the time-setting controller and its helpers.
//   - field widths and maximum values for seconds, minutes, hours
//   - state_e: controller FSM states (COMMIT is a one-cycle transient)
//   - MODE_* : values shown on the mode LEDs for each state
//   - BLK_*  : bit positions in the six-digit blank mask
//   - wrap_inc / wrap_dec: modulo (max+1) step helpers
package time_pkg;

  localparam int SEC_W  = 6;
  localparam int MIN_W  = 6;
  localparam int HOUR_W = 5;

  localparam logic [SEC_W-1:0]  MAX_SEC  = 6'd59;
  localparam logic [MIN_W-1:0]  MAX_MIN  = 6'd59;
  localparam logic [HOUR_W-1:0] MAX_HOUR = 5'd23;

  typedef enum logic [2:0] {
    ST_RUN    = 3'd0,
    ST_SET_H  = 3'd1,
    ST_SET_M  = 3'd2,
    ST_SET_S  = 3'd3,
    ST_COMMIT = 3'd4
  } state_e;

  localparam logic [1:0] MODE_RUN   = 2'd0;
  localparam logic [1:0] MODE_SET_H = 2'd1;
  localparam logic [1:0] MODE_SET_M = 2'd2;
  localparam logic [1:0] MODE_SET_S = 2'd3;

  localparam int BLK_SEC_U  = 0;
  localparam int BLK_SEC_T  = 1;
  localparam int BLK_MIN_U  = 2;
  localparam int BLK_MIN_T  = 3;
  localparam int BLK_HOUR_U = 4;
  localparam int BLK_HOUR_T = 5;

  // Step up modulo (max_v+1); an out-of-range value also lands on 0.
  function automatic logic [5:0] wrap_inc(input logic [5:0] v, input logic [5:0] max_v);
    logic [5:0] r;
    if (v >= max_v) r = 6'd0;
    else            r = v + 6'd1;
    return r;
  endfunction

  // Step down modulo (max_v+1); an out-of-range value is pulled to max_v.
  function automatic logic [5:0] wrap_dec(input logic [5:0] v, input logic [5:0] max_v);
    logic [5:0] r;
    if (v == 6'd0 || v > max_v) r = max_v;
    else                        r = v - 6'd1;
    return r;
  endfunction

  function automatic logic [1:0] state_mode(input state_e s);
    logic [1:0] m;
    case (s)
      ST_SET_H: m = MODE_SET_H;
      ST_SET_M: m = MODE_SET_M;
      ST_SET_S: m = MODE_SET_S;
      default:  m = MODE_RUN;
    endcase
    return m;
  endfunction

  // Digits belonging to the field being edited in state s.
  function automatic logic [5:0] field_mask(input state_e s);
    logic [5:0] m;
    m = 6'd0;
    case (s)
      ST_SET_H: begin m[BLK_HOUR_U] = 1'b1; m[BLK_HOUR_T] = 1'b1; end
      ST_SET_M: begin m[BLK_MIN_U]  = 1'b1; m[BLK_MIN_T]  = 1'b1; end
      ST_SET_S: begin m[BLK_SEC_U]  = 1'b1; m[BLK_SEC_T]  = 1'b1; end
      default:  m = 6'd0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/time_set_ctrl_if.sv
// time_set_ctrl_if: groups the button inputs, live-time inputs and all
// controller outputs (counter control, load value, display feed, LEDs).
// There is no valid/ready handshake on this bus: buttons are level signals
// whose rising edges are events, `load` is a single-cycle strobe that the
// time counter must honour in the cycle it is high, and every other output
// is a registered level valid in every cycle.
//   slave  : the controller (time_set_ctrl)
//   master : whatever drives buttons / live time and consumes the outputs
interface time_set_ctrl_if;
  import time_pkg::*;

  logic              btn_mode;
  logic              btn_up;
  logic              btn_down;
  logic [SEC_W-1:0]  cur_sec;
  logic [MIN_W-1:0]  cur_min;
  logic [HOUR_W-1:0] cur_hour;

  logic              count_en;
  logic              load;
  logic [SEC_W-1:0]  load_sec;
  logic [MIN_W-1:0]  load_min;
  logic [HOUR_W-1:0] load_hour;
  logic [SEC_W-1:0]  disp_sec;
  logic [MIN_W-1:0]  disp_min;
  logic [HOUR_W-1:0] disp_hour;
  logic [5:0]        blank;
  logic [1:0]        mode;
  logic [2:0]        dbg_state;

  modport slave (
    input  btn_mode, btn_up, btn_down, cur_sec, cur_min, cur_hour,
    output count_en, load, load_sec, load_min, load_hour,
           disp_sec, disp_min, disp_hour, blank, mode, dbg_state
  );

  modport master (
    output btn_mode, btn_up, btn_down, cur_sec, cur_min, cur_hour,
    input  count_en, load, load_sec, load_min, load_hour,
           disp_sec, disp_min, disp_hour, blank, mode, dbg_state
  );
endinterface

// File: rtl/time_set_ctrl_blink_gen.sv
// blink_gen: blink phase generator plus inactivity timer.
//   clk, rst : clock, synchronous active-high reset
//   restart  : clears both counters and forces the "on" phase
//   phase    : 0 = digits shown, 1 = edited digits blanked
//   expired  : high once TIMEOUT cycles have elapsed since the last restart
// The phase toggles every BLINK_HALF cycles; the timer saturates so that
// expired stays high until the next restart.
module blink_gen #(
  parameter int BLINK_HALF = 25_000_000,
  parameter int TIMEOUT    = 500_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic phase,
  output logic expired
);

  localparam int BW = (BLINK_HALF > 2) ? $clog2(BLINK_HALF) : 1;
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [BW-1:0] B_LAST = BW'(BLINK_HALF - 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  logic [BW-1:0] bcnt_q, bcnt_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          phase_q, phase_d;

  always_comb begin
    bcnt_d  = bcnt_q;
    tcnt_d  = tcnt_q;
    phase_d = phase_q;
    if (restart) begin
      bcnt_d  = '0;
      tcnt_d  = '0;
      phase_d = 1'b0;
    end else begin
      if (bcnt_q == B_LAST) begin
        bcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        bcnt_d = bcnt_q + 1'b1;
      end
      if (tcnt_q != T_LAST) tcnt_d = tcnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bcnt_q  <= '0;
      tcnt_q  <= '0;
      phase_q <= 1'b0;
    end else begin
      bcnt_q  <= bcnt_d;
      tcnt_q  <= tcnt_d;
      phase_q <= phase_d;
    end
  end

  assign phase   = phase_q;
  assign expired = (tcnt_q == T_LAST);

endmodule

// File: rtl/time_set_ctrl.sv
// time_set_ctrl: time-setting controller between the button conditioner,
// the time counter and the six-digit display scanner.
//   clk, rst : clock, synchronous active-high reset
//   bus      : time_set_ctrl_if.slave
//     btn_mode/up/down   debounced button levels (rising edge = press)
//     cur_*              live time from the counter
//     count_en           0 freezes the counter while editing
//     load, load_*       one-cycle load strobe and the value to load
//     disp_*, blank      display value and per-digit blank mask
//     mode, dbg_state    LED mode code and raw FSM state
// Flow: RUN -mode-> SET_H -mode-> SET_M -mode-> SET_S -mode-> COMMIT -> RUN.
// Inactivity in any SET state returns to RUN without loading.
module time_set_ctrl
  import time_pkg::*;
#(
  parameter int BLINK_HALF = 25_000_000,
  parameter int TIMEOUT    = 500_000_000
) (
  input  logic                 clk,
  input  logic                 rst,
  time_set_ctrl_if.slave       bus
);

  // ---------------- button edge detection ----------------
  logic [2:0] prev_q, prev_d;   // {mode, up, down}
  logic press_mode, press_up, press_down, any_press;
  logic step_up, step_dn;

  assign prev_d     = {bus.btn_mode, bus.btn_up, bus.btn_down};
  assign press_mode = bus.btn_mode & ~prev_q[2];
  assign press_up   = bus.btn_up   & ~prev_q[1];
  assign press_down = bus.btn_down & ~prev_q[0];
  assign any_press  = press_mode | press_up | press_down;
  // Up and down together cancel; mode outranks both (checked first below).
  assign step_up    = press_up & ~press_down;
  assign step_dn    = press_down & ~press_up;

  // ---------------- state and edit registers ----------------
  state_e            state_q, state_d;
  logic [HOUR_W-1:0] edit_hour_q, edit_hour_d;
  logic [MIN_W-1:0]  edit_min_q,  edit_min_d;
  logic [SEC_W-1:0]  edit_sec_q,  edit_sec_d;

  logic blink_phase, timed_out, restart;
  logic in_edit_q, in_edit_d;

  assign in_edit_q = (state_q == ST_SET_H) || (state_q == ST_SET_M) || (state_q == ST_SET_S);
  assign in_edit_d = (state_d == ST_SET_H) || (state_d == ST_SET_M) || (state_d == ST_SET_S);

  // Counters sit cleared outside the edit states, and restart on any press
  // or state change, so both the blink and the timeout start fresh on entry.
  assign restart = ~in_edit_q | any_press | (state_d != state_q);

  blink_gen #(
    .BLINK_HALF (BLINK_HALF),
    .TIMEOUT    (TIMEOUT)
  ) u_blink (
    .clk     (clk),
    .rst     (rst),
    .restart (restart),
    .phase   (blink_phase),
    .expired (timed_out)
  );

  always_comb begin
    state_d     = state_q;
    edit_hour_d = edit_hour_q;
    edit_min_d  = edit_min_q;
    edit_sec_d  = edit_sec_q;
    case (state_q)
      ST_RUN: begin
        if (press_mode) begin
          state_d     = ST_SET_H;
          edit_hour_d = bus.cur_hour;
          edit_min_d  = bus.cur_min;
          edit_sec_d  = bus.cur_sec;
        end
      end
      ST_SET_H: begin
        if (press_mode)                  state_d = ST_SET_M;
        else if (step_up)                edit_hour_d = HOUR_W'(wrap_inc({1'b0, edit_hour_q}, {1'b0, MAX_HOUR}));
        else if (step_dn)                edit_hour_d = HOUR_W'(wrap_dec({1'b0, edit_hour_q}, {1'b0, MAX_HOUR}));
        else if (timed_out && !any_press) state_d = ST_RUN;
      end
      ST_SET_M: begin
        if (press_mode)                  state_d = ST_SET_S;
        else if (step_up)                edit_min_d = wrap_inc(edit_min_q, MAX_MIN);
        else if (step_dn)                edit_min_d = wrap_dec(edit_min_q, MAX_MIN);
        else if (timed_out && !any_press) state_d = ST_RUN;
      end
      ST_SET_S: begin
        if (press_mode)                  state_d = ST_COMMIT;
        else if (step_up)                edit_sec_d = wrap_inc(edit_sec_q, MAX_SEC);
        else if (step_dn)                edit_sec_d = wrap_dec(edit_sec_q, MAX_SEC);
        else if (timed_out && !any_press) state_d = ST_RUN;
      end
      ST_COMMIT: state_d = ST_RUN;
      default:   state_d = ST_RUN;
    endcase
  end

  // ---------------- registered outputs ----------------
  // Outputs are computed from the next state so that a press sampled in
  // cycle N is reflected on the outputs in cycle N+1.
  logic              count_en_q, count_en_d;
  logic              load_q, load_d;
  logic [HOUR_W-1:0] load_hour_q, load_hour_d;
  logic [MIN_W-1:0]  load_min_q,  load_min_d;
  logic [SEC_W-1:0]  load_sec_q,  load_sec_d;
  logic [HOUR_W-1:0] disp_hour_q, disp_hour_d;
  logic [MIN_W-1:0]  disp_min_q,  disp_min_d;
  logic [SEC_W-1:0]  disp_sec_q,  disp_sec_d;
  logic [1:0]        mode_q, mode_d;

  always_comb begin
    count_en_d  = ~in_edit_d;
    load_d      = (state_d == ST_COMMIT);
    load_hour_d = load_hour_q;
    load_min_d  = load_min_q;
    load_sec_d  = load_sec_q;
    if (load_d) begin
      load_hour_d = edit_hour_d;
      load_min_d  = edit_min_d;
      load_sec_d  = edit_sec_d;
    end
    if (in_edit_d) begin
      disp_hour_d = edit_hour_d;
      disp_min_d  = edit_min_d;
      disp_sec_d  = edit_sec_d;
    end else begin
      disp_hour_d = bus.cur_hour;
      disp_min_d  = bus.cur_min;
      disp_sec_d  = bus.cur_sec;
    end
    mode_d = state_mode(state_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q      <= '0;
      state_q     <= ST_RUN;
      edit_hour_q <= '0;
      edit_min_q  <= '0;
      edit_sec_q  <= '0;
      count_en_q  <= 1'b1;
      load_q      <= 1'b0;
      load_hour_q <= '0;
      load_min_q  <= '0;
      load_sec_q  <= '0;
      disp_hour_q <= '0;
      disp_min_q  <= '0;
      disp_sec_q  <= '0;
      mode_q      <= MODE_RUN;
    end else begin
      prev_q      <= prev_d;
      state_q     <= state_d;
      edit_hour_q <= edit_hour_d;
      edit_min_q  <= edit_min_d;
      edit_sec_q  <= edit_sec_d;
      count_en_q  <= count_en_d;
      load_q      <= load_d;
      load_hour_q <= load_hour_d;
      load_min_q  <= load_min_d;
      load_sec_q  <= load_sec_d;
      disp_hour_q <= disp_hour_d;
      disp_min_q  <= disp_min_d;
      disp_sec_q  <= disp_sec_d;
      mode_q      <= mode_d;
    end
  end

  assign bus.count_en  = count_en_q;
  assign bus.load      = load_q;
  assign bus.load_hour = load_hour_q;
  assign bus.load_min  = load_min_q;
  assign bus.load_sec  = load_sec_q;
  assign bus.disp_hour = disp_hour_q;
  assign bus.disp_min  = disp_min_q;
  assign bus.disp_sec  = disp_sec_q;
  assign bus.mode      = mode_q;
  assign bus.dbg_state = state_q;
  // Decoded purely from the state and phase flops; no input reaches it.
  assign bus.blank     = field_mask(state_q) & {6{blink_phase}};

endmodule

// File: tb/tb_time_set_ctrl.sv
// tb_time_set_ctrl: directed bench for time_set_ctrl with BLINK_HALF=4 and
// TIMEOUT=64. Driver tasks change inputs on the falling edge and push the
// hand-computed output snapshot expected after the next rising edge, tagged
// with that edge's number. A monitor samples 1 time unit after every rising
// edge, pops and compares due snapshots, and checks every load pulse against
// a separate queue of expected load values.
module tb_time_set_ctrl;
  import time_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  time_set_ctrl_if bus();

  time_set_ctrl #(
    .BLINK_HALF (4),
    .TIMEOUT    (64)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // snapshot = {mode, count_en, load, hour, min, sec, blank}
  localparam int SW = 27;
  logic [SW-1:0] exp_q[$];
  int            tag_q[$];
  logic [16:0]   exp_load_q[$];   // {hour, min, sec}

  int cyc    = 0;
  int n_cmp  = 0;
  int n_fail = 0;

  // ---------------- driver tasks ----------------
  task automatic tick(input logic m, input logic u, input logic d);
    @(negedge clk);
    bus.btn_mode = m;
    bus.btn_up   = u;
    bus.btn_down = d;
  endtask

  task automatic expect_out(input logic [1:0] md, input logic ce, input logic ld,
                            input logic [4:0] h, input logic [5:0] mi,
                            input logic [5:0] s, input logic [5:0] bl);
    exp_q.push_back({md, ce, ld, h, mi, s, bl});
    tag_q.push_back(cyc + 1);
  endtask

  // n presses of the given up/down combination, each followed by a release
  task automatic press_n(input logic u, input logic d, input int n);
    for (int k = 0; k < n; k++) begin
      tick(1'b0, u, d);
      tick(1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic press_mode();
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(posedge clk) begin
    logic [SW-1:0] got, want;
    cyc = cyc + 1;
    #1;
    if (bus.load === 1'b1) begin
      n_cmp = n_cmp + 1;
      if (exp_load_q.size() == 0) begin
        n_fail = n_fail + 1;
        $display("FAIL load_unexpected cyc=%0d got load=1 %0d:%0d:%0d, required no load",
                 cyc, bus.load_hour, bus.load_min, bus.load_sec);
      end else begin
        logic [16:0] lw;
        lw = exp_load_q.pop_front();
        if ({bus.load_hour, bus.load_min, bus.load_sec} !== lw) begin
          n_fail = n_fail + 1;
          $display("FAIL load_value cyc=%0d got %0d:%0d:%0d required %0d:%0d:%0d",
                   cyc, bus.load_hour, bus.load_min, bus.load_sec, lw[16:12], lw[11:6], lw[5:0]);
        end
      end
    end
    while (tag_q.size() > 0 && tag_q[0] <= cyc) begin
      void'(tag_q.pop_front());
      want = exp_q.pop_front();
      got  = {bus.mode, bus.count_en, bus.load, bus.disp_hour, bus.disp_min, bus.disp_sec, bus.blank};
      n_cmp = n_cmp + 1;
      if (got !== want) begin
        n_fail = n_fail + 1;
        $display("FAIL outputs cyc=%0d got mode=%0d ce=%b ld=%b disp=%0d:%0d:%0d blank=%b required mode=%0d ce=%b ld=%b disp=%0d:%0d:%0d blank=%b",
                 cyc, got[26:25], got[24], got[23], got[22:18], got[17:12], got[11:6], got[5:0],
                 want[26:25], want[24], want[23], want[22:18], want[17:12], want[11:6], want[5:0]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got no end of test, required finish", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    bus.btn_mode = 1'b0;
    bus.btn_up   = 1'b0;
    bus.btn_down = 1'b0;
    bus.cur_hour = 5'd12;
    bus.cur_min  = 6'd34;
    bus.cur_sec  = 6'd56;

    // Reset state
    tick(0, 0, 0);
    tick(0, 0, 0);
    expect_out(2'd0, 1, 0, 5'd0, 6'd0, 6'd0, 6'd0);
    @(negedge clk);
    rst = 1'b0;
    expect_out(2'd0, 1, 0, 5'd12, 6'd34, 6'd56, 6'd0);
    tick(0, 0, 0);
    expect_out(2'd0, 1, 0, 5'd12, 6'd34, 6'd56, 6'd0);

    // Up/down in RUN are ignored
    tick(0, 1, 0);
    expect_out(2'd0, 1, 0, 5'd12, 6'd34, 6'd56, 6'd0);
    tick(0, 0, 0);

    // Enter SET_H, watch the hour field blink
    tick(1, 0, 0);
    expect_out(2'd1, 0, 0, 5'd12, 6'd34, 6'd56, 6'd0);
    for (int i = 1; i <= 9; i++) begin
      tick(0, 0, 0);
      expect_out(2'd1, 0, 0, 5'd12, 6'd34, 6'd56, ((i / 4) % 2 == 1) ? 6'b110000 : 6'b000000);
    end

    // Hour wrap: 12 down x13 -> 23, up -> 0, down -> 23
    press_n(0, 1, 13);
    expect_out(2'd1, 0, 0, 5'd23, 6'd34, 6'd56, 6'd0);
    press_n(1, 0, 1);
    expect_out(2'd1, 0, 0, 5'd0, 6'd34, 6'd56, 6'd0);
    press_n(0, 1, 1);
    expect_out(2'd1, 0, 0, 5'd23, 6'd34, 6'd56, 6'd0);
    press_n(1, 0, 1);

    // Up+down together: no change
    tick(0, 1, 1);
    expect_out(2'd1, 0, 0, 5'd0, 6'd34, 6'd56, 6'd0);
    tick(0, 0, 0);

    // Hold up for 20 cycles: one increment only
    tick(0, 1, 0);
    expect_out(2'd1, 0, 0, 5'd1, 6'd34, 6'd56, 6'd0);
    for (int i = 1; i < 20; i++) tick(0, 1, 0);
    expect_out(2'd1, 0, 0, 5'd1, 6'd34, 6'd56, 6'd0);
    tick(0, 0, 0);
    expect_out(2'd1, 0, 0, 5'd1, 6'd34, 6'd56, 6'b110000);

    // Up to 7
    press_n(1, 0, 6);
    expect_out(2'd1, 0, 0, 5'd7, 6'd34, 6'd56, 6'd0);

    // Mode+up: SET_M, hour unchanged
    tick(1, 1, 0);
    expect_out(2'd2, 0, 0, 5'd7, 6'd34, 6'd56, 6'd0);
    tick(0, 0, 0);
    tick(0, 0, 0);
    tick(0, 0, 0);
    tick(0, 0, 0);
    expect_out(2'd2, 0, 0, 5'd7, 6'd34, 6'd56, 6'b001100);

    // Minute wrap: 34 down x34 -> 0, down -> 59, up -> 0, up x8 -> 8
    press_n(0, 1, 34);
    expect_out(2'd2, 0, 0, 5'd7, 6'd0, 6'd56, 6'd0);
    press_n(0, 1, 1);
    expect_out(2'd2, 0, 0, 5'd7, 6'd59, 6'd56, 6'd0);
    press_n(1, 0, 1);
    expect_out(2'd2, 0, 0, 5'd7, 6'd0, 6'd56, 6'd0);
    press_n(1, 0, 8);
    expect_out(2'd2, 0, 0, 5'd7, 6'd8, 6'd56, 6'd0);

    // SET_S: 56 up x3 -> 59, up -> 0, up x9 -> 9
    tick(1, 0, 0);
    expect_out(2'd3, 0, 0, 5'd7, 6'd8, 6'd56, 6'd0);
    tick(0, 0, 0);
    press_n(1, 0, 3);
    expect_out(2'd3, 0, 0, 5'd7, 6'd8, 6'd59, 6'd0);
    press_n(1, 0, 1);
    expect_out(2'd3, 0, 0, 5'd7, 6'd8, 6'd0, 6'd0);
    press_n(1, 0, 9);
    expect_out(2'd3, 0, 0, 5'd7, 6'd8, 6'd9, 6'd0);

    // Commit 07:08:09: one load cycle, then RUN
    tick(1, 0, 0);
    exp_load_q.push_back({5'd7, 6'd8, 6'd9});
    expect_out(2'd0, 1, 1, 5'd12, 6'd34, 6'd56, 6'd0);
    tick(0, 0, 0);
    expect_out(2'd0, 1, 0, 5'd12, 6'd34, 6'd56, 6'd0);
    tick(0, 0, 0);
    expect_out(2'd0, 1, 0, 5'd12, 6'd34, 6'd56, 6'd0);

    // Timeout in SET_S: back to RUN after 64 idle cycles, no load
    press_mode();
    press_mode();
    tick(1, 0, 0);
    expect_out(2'd3, 0, 0, 5'd12, 6'd34, 6'd56, 6'd0);
    for (int i = 1; i <= 66; i++) begin
      tick(0, 0, 0);
      if (i == 4)  expect_out(2'd3, 0, 0, 5'd12, 6'd34, 6'd56, 6'b000011);
      if (i == 63) expect_out(2'd3, 0, 0, 5'd12, 6'd34, 6'd56, 6'b000011);
      if (i == 64) expect_out(2'd0, 1, 0, 5'd12, 6'd34, 6'd56, 6'd0);
    end

    // Reset mid-edit in SET_M: RUN with reset values, no load
    press_mode();
    press_mode();
    expect_out(2'd2, 0, 0, 5'd12, 6'd34, 6'd56, 6'd0);
    @(negedge clk);
    rst = 1'b1;
    expect_out(2'd0, 1, 0, 5'd0, 6'd0, 6'd0, 6'd0);
    @(negedge clk);
    rst = 1'b0;
    expect_out(2'd0, 1, 0, 5'd12, 6'd34, 6'd56, 6'd0);
    for (int i = 0; i < 4; i++) tick(0, 0, 0);
    expect_out(2'd0, 1, 0, 5'd12, 6'd34, 6'd56, 6'd0);
    tick(0, 0, 0);
    tick(0, 0, 0);

    // Everything expected must have been seen
    n_cmp = n_cmp + 1;
    if (exp_q.size() != 0 || exp_load_q.size() != 0) begin
      n_fail = n_fail + 1;
      $display("FAIL queues_drained got %0d outputs / %0d loads pending, required 0 / 0",
               exp_q.size(), exp_load_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
